// File: rtl/sensor_pwr_sequencer_if.sv
// Pin-side bundle of the sensor power sequencer: the level power request and
// power-good inputs from the board, plus the regulator/INCK/XCLR enables and
// the status word reported back to the control PIO.
//   master : the sequencer, which drives the enables and the status
//   slave  : the environment (PIO/board), which drives the request and power-good
interface sensor_pwr_sequencer_if;
  logic       pwr_req_i;
  logic       pg_1v2_i;
  logic       pg_1v8_i;
  logic       pg_3v3_i;
  logic       reg_1v2_en_o;
  logic       reg_1v8_en_o;
  logic       reg_3v3_en_o;
  logic       inck_en_o;
  logic       xclr_o;
  logic       ready_o;
  logic       busy_o;
  logic       fault_o;
  logic [3:0] state_o;

  modport master (
    input  pwr_req_i,
    input  pg_1v2_i,
    input  pg_1v8_i,
    input  pg_3v3_i,
    output reg_1v2_en_o,
    output reg_1v8_en_o,
    output reg_3v3_en_o,
    output inck_en_o,
    output xclr_o,
    output ready_o,
    output busy_o,
    output fault_o,
    output state_o
  );

  modport slave (
    output pwr_req_i,
    output pg_1v2_i,
    output pg_1v8_i,
    output pg_3v3_i,
    input  reg_1v2_en_o,
    input  reg_1v8_en_o,
    input  reg_3v3_en_o,
    input  inck_en_o,
    input  xclr_o,
    input  ready_o,
    input  busy_o,
    input  fault_o,
    input  state_o
  );
endinterface

// File: rtl/sensor_pwr_sequencer.sv
// SLVS-EC sensor power sequencer.
// Walks the sensor through 1V2 -> 1V8 -> 3V3 -> INCK -> XCLR release -> ON and
// back down in reverse order, each step held for a programmable number of
// cycles. Every output is a registered decode of the state being entered, so
// an output changes on the same edge that enters its state.
// Optional build macro PG_CHECK_EN: enables power-good supervision. Without it
// the pg inputs are ignored, FAULT can never be entered and fault_o is 0.
module sensor_pwr_sequencer #(
  parameter int CNT_W    = 24,
  parameter int DLY_RAIL = 50000,
  parameter int DLY_INCK = 5000,
  parameter int DLY_XCLR = 1000000,
  parameter int DLY_DN   = 5000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  sensor_pwr_sequencer_if.master pwr_if
);

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_UP_1V2  = 4'd1,
    ST_UP_1V8  = 4'd2,
    ST_UP_3V3  = 4'd3,
    ST_UP_INCK = 4'd4,
    ST_UP_XCLR = 4'd5,
    ST_ON      = 4'd6,
    ST_DN_XCLR = 4'd7,
    ST_DN_INCK = 4'd8,
    ST_DN_3V3  = 4'd9,
    ST_DN_1V8  = 4'd10,
    ST_DN_1V2  = 4'd11,
    ST_FAULT   = 4'd15
  } state_t;

  // A timed state ends when the counter reaches its delay minus one.
  localparam logic [CNT_W-1:0] L_RAIL_LAST = CNT_W'(DLY_RAIL - 1);
  localparam logic [CNT_W-1:0] L_INCK_LAST = CNT_W'(DLY_INCK - 1);
  localparam logic [CNT_W-1:0] L_XCLR_LAST = CNT_W'(DLY_XCLR - 1);
  localparam logic [CNT_W-1:0] L_DN_LAST   = CNT_W'(DLY_DN - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_step_done;
  logic             w_req;
  logic             w_fault;

  logic             r_reg_1v2_en;
  logic             r_reg_1v8_en;
  logic             r_reg_3v3_en;
  logic             r_inck_en;
  logic             r_xclr;
  logic             r_ready;
  logic             r_busy;
  logic             w_reg_1v2_en_next;
  logic             w_reg_1v8_en_next;
  logic             w_reg_3v3_en_next;
  logic             w_inck_en_next;
  logic             w_xclr_next;
  logic             w_ready_next;
  logic             w_busy_next;

  assign w_req = pwr_if.pwr_req_i;

  // Terminal count of the current timed state; untimed states never finish.
  always_comb begin
    w_last = '0;
    case (r_state)
      ST_UP_1V2, ST_UP_1V8, ST_UP_3V3:                  w_last = L_RAIL_LAST;
      ST_UP_INCK:                                       w_last = L_INCK_LAST;
      ST_UP_XCLR:                                       w_last = L_XCLR_LAST;
      ST_DN_XCLR, ST_DN_INCK, ST_DN_3V3, ST_DN_1V8,
      ST_DN_1V2:                                        w_last = L_DN_LAST;
      default:                                          w_last = '0;
    endcase
  end

  assign w_step_done = (r_cnt == w_last);

`ifdef PG_CHECK_EN
  logic w_rail_drop;
  logic w_pg_not_good;
  logic r_fault;

  // Supervision: a rail counts as established once its own step has ended
  // with power-good high; losing pg on an established rail is a fault at
  // once, and a rail step cannot end without its pg.
  always_comb begin
    w_rail_drop   = 1'b0;
    w_pg_not_good = 1'b0;
    case (r_state)
      ST_UP_1V2: begin
        w_pg_not_good = w_step_done && !pwr_if.pg_1v2_i;
      end
      ST_UP_1V8: begin
        w_rail_drop   = !pwr_if.pg_1v2_i;
        w_pg_not_good = w_step_done && !pwr_if.pg_1v8_i;
      end
      ST_UP_3V3: begin
        w_rail_drop   = !pwr_if.pg_1v2_i || !pwr_if.pg_1v8_i;
        w_pg_not_good = w_step_done && !pwr_if.pg_3v3_i;
      end
      ST_UP_INCK, ST_UP_XCLR, ST_ON: begin
        w_rail_drop = !pwr_if.pg_1v2_i || !pwr_if.pg_1v8_i || !pwr_if.pg_3v3_i;
      end
      default: begin
        w_rail_drop   = 1'b0;
        w_pg_not_good = 1'b0;
      end
    endcase
  end

  assign w_fault = w_rail_drop || w_pg_not_good;

  // Fault flag is a registered decode of entering FAULT.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= (w_state_next == ST_FAULT);
    end
  end

  assign pwr_if.fault_o = r_fault;
`else
  logic w_unused_pg;

  assign w_unused_pg    = pwr_if.pg_1v2_i ^ pwr_if.pg_1v8_i ^ pwr_if.pg_3v3_i;
  assign w_fault        = 1'b0;
  assign pwr_if.fault_o = 1'b0;
`endif

  // Next-state selection and decode of the outputs for the state being entered.
  always_comb begin
    w_state_next = r_state;
    if (w_fault) begin
      // A fault beats any request change seen in the same cycle.
      w_state_next = ST_FAULT;
    end else begin
      case (r_state)
        ST_OFF:     if (w_req) w_state_next = ST_UP_1V2;
        // The request is looked at only when an up step ends; an abort
        // enters the down step that undoes the resource just enabled.
        ST_UP_1V2:  if (w_step_done) w_state_next = w_req ? ST_UP_1V8  : ST_DN_1V2;
        ST_UP_1V8:  if (w_step_done) w_state_next = w_req ? ST_UP_3V3  : ST_DN_1V8;
        ST_UP_3V3:  if (w_step_done) w_state_next = w_req ? ST_UP_INCK : ST_DN_3V3;
        ST_UP_INCK: if (w_step_done) w_state_next = w_req ? ST_UP_XCLR : ST_DN_INCK;
        ST_UP_XCLR: if (w_step_done) w_state_next = w_req ? ST_ON      : ST_DN_XCLR;
        ST_ON:      if (!w_req) w_state_next = ST_DN_XCLR;
        // Power-down always runs to completion; the request is ignored.
        ST_DN_XCLR: if (w_step_done) w_state_next = ST_DN_INCK;
        ST_DN_INCK: if (w_step_done) w_state_next = ST_DN_3V3;
        ST_DN_3V3:  if (w_step_done) w_state_next = ST_DN_1V8;
        ST_DN_1V8:  if (w_step_done) w_state_next = ST_DN_1V2;
        ST_DN_1V2:  if (w_step_done) w_state_next = ST_OFF;
        ST_FAULT:   if (!w_req) w_state_next = ST_OFF;
        default:    w_state_next = ST_OFF;
      endcase
    end

    // Each resource stays on from the up step that enables it until the
    // down step that removes it; FAULT and OFF have everything off.
    w_reg_1v2_en_next = w_state_next inside {ST_UP_1V2, ST_UP_1V8, ST_UP_3V3,
                                             ST_UP_INCK, ST_UP_XCLR, ST_ON,
                                             ST_DN_XCLR, ST_DN_INCK, ST_DN_3V3,
                                             ST_DN_1V8};
    w_reg_1v8_en_next = w_state_next inside {ST_UP_1V8, ST_UP_3V3, ST_UP_INCK,
                                             ST_UP_XCLR, ST_ON, ST_DN_XCLR,
                                             ST_DN_INCK, ST_DN_3V3};
    w_reg_3v3_en_next = w_state_next inside {ST_UP_3V3, ST_UP_INCK, ST_UP_XCLR,
                                             ST_ON, ST_DN_XCLR, ST_DN_INCK};
    w_inck_en_next    = w_state_next inside {ST_UP_INCK, ST_UP_XCLR, ST_ON,
                                             ST_DN_XCLR};
    w_xclr_next       = w_state_next inside {ST_UP_XCLR, ST_ON};
    w_ready_next      = (w_state_next == ST_ON);
    w_busy_next       = w_state_next inside {ST_UP_1V2, ST_UP_1V8, ST_UP_3V3,
                                             ST_UP_INCK, ST_UP_XCLR,
                                             ST_DN_XCLR, ST_DN_INCK, ST_DN_3V3,
                                             ST_DN_1V8, ST_DN_1V2};
  end

  // State register and step counter; the counter restarts on every state change.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Registered pin outputs; reset drops everything at once with no ramp-down.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_reg_1v2_en <= 1'b0;
      r_reg_1v8_en <= 1'b0;
      r_reg_3v3_en <= 1'b0;
      r_inck_en    <= 1'b0;
      r_xclr       <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_reg_1v2_en <= w_reg_1v2_en_next;
      r_reg_1v8_en <= w_reg_1v8_en_next;
      r_reg_3v3_en <= w_reg_3v3_en_next;
      r_inck_en    <= w_inck_en_next;
      r_xclr       <= w_xclr_next;
      r_ready      <= w_ready_next;
      r_busy       <= w_busy_next;
    end
  end

  assign pwr_if.reg_1v2_en_o = r_reg_1v2_en;
  assign pwr_if.reg_1v8_en_o = r_reg_1v8_en;
  assign pwr_if.reg_3v3_en_o = r_reg_3v3_en;
  assign pwr_if.inck_en_o    = r_inck_en;
  assign pwr_if.xclr_o       = r_xclr;
  assign pwr_if.ready_o      = r_ready;
  assign pwr_if.busy_o       = r_busy;
  assign pwr_if.state_o      = r_state;

endmodule

// File: tb/tb_sensor_pwr_sequencer.sv
// Testbench for sensor_pwr_sequencer with short delays (rail 4, INCK 3,
// XCLR 5, power-down 2). Observed outputs are packed as
// {state[3:0], fault, busy, ready, xclr, inck, en_3v3, en_1v8, en_1v2}.
module tb_sensor_pwr_sequencer;
  localparam int CNT_W    = 8;
  localparam int DLY_RAIL = 4;
  localparam int DLY_INCK = 3;
  localparam int DLY_XCLR = 5;
  localparam int DLY_DN   = 2;

  logic clk_clk = 1'b0;
  logic reset_reset;

  always #5 clk_clk = ~clk_clk;

  sensor_pwr_sequencer_if pwr_if ();

  sensor_pwr_sequencer #(
    .CNT_W    (CNT_W),
    .DLY_RAIL (DLY_RAIL),
    .DLY_INCK (DLY_INCK),
    .DLY_XCLR (DLY_XCLR),
    .DLY_DN   (DLY_DN)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .pwr_if      (pwr_if)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [2:0]  pg;    // {3v3, 1v8, 1v2}
    int          n;     // clock edges to apply these inputs for
    logic [11:0] exp;   // expected outputs after the last edge
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: the sensor is described by how many resources are on
  // (level 0..6 = none, 1V2, 1V8, 3V3, INCK, XCLR, ready), the direction of
  // travel, the cycles left in the current step and a latched fault.
  int   m_level = 0;
  int   m_dir   = 0;
  int   m_left  = 0;
  bit   m_fault = 1'b0;

  function automatic vec_t mk(logic rst, logic req, logic [2:0] pg, int n, logic [11:0] exp);
    vec_t v;
    v.rst = rst; v.req = req; v.pg = pg; v.n = n; v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] dut_vec();
    return {pwr_if.state_o, pwr_if.fault_o, pwr_if.busy_o, pwr_if.ready_o,
            pwr_if.xclr_o, pwr_if.inck_en_o, pwr_if.reg_3v3_en_o,
            pwr_if.reg_1v8_en_o, pwr_if.reg_1v2_en_o};
  endfunction

  function automatic int up_duration(int lvl);
    if (lvl <= 3) return DLY_RAIL;
    if (lvl == 4) return DLY_INCK;
    return DLY_XCLR;
  endfunction

  function automatic logic [11:0] model_vec();
    int st;
    logic [7:0] b;
    if (m_fault) return 12'hF80;
    if (m_dir == 0)     st = (m_level == 0) ? 0 : 6;
    else if (m_dir > 0) st = m_level;
    else                st = 11 - m_level;
    b = {1'b0, (m_dir != 0), (m_level == 6), (m_level >= 5), (m_level >= 4),
         (m_level >= 3), (m_level >= 2), (m_level >= 1)};
    return {st[3:0], b};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(logic rst, logic req, logic [2:0] pg);
    bit fault_now;
    int proven;
    fault_now = 1'b0;
`ifdef PG_CHECK_EN
    proven = 0;
    if (m_dir > 0)                        proven = (m_level - 1 > 3) ? 3 : m_level - 1;
    else if (m_dir == 0 && m_level == 6)  proven = 3;
    for (int k = 0; k < 3; k++)
      if (k < proven && !pg[k]) fault_now = 1'b1;
    if (m_dir > 0 && m_left == 1 && m_level <= 3 && !pg[m_level-1]) fault_now = 1'b1;
`else
    proven = 0;
`endif
    if (rst) begin
      m_level = 0; m_dir = 0; m_left = 0; m_fault = 1'b0;
    end else if (m_fault) begin
      if (!req) begin
        m_fault = 1'b0; m_level = 0; m_dir = 0;
      end
    end else if (fault_now) begin
      m_fault = 1'b1; m_level = 0; m_dir = 0;
    end else if (m_dir == 0) begin
      if (m_level == 0 && req) begin
        m_level = 1; m_dir = 1; m_left = up_duration(1);
      end else if (m_level == 6 && !req) begin
        m_level = 4; m_dir = -1; m_left = DLY_DN;
      end
    end else if (m_dir > 0) begin
      if (m_left > 1) m_left--;
      else if (!req) begin
        m_level--; m_dir = -1; m_left = DLY_DN;
      end else begin
        m_level++;
        if (m_level == 6) m_dir = 0;
        else m_left = up_duration(m_level);
      end
    end else begin
      if (m_left > 1) m_left--;
      else if (m_level == 0) m_dir = 0;
      else begin
        m_level--; m_left = DLY_DN;
      end
    end
  endtask

  task automatic check(string name, logic [11:0] exp);
    logic [11:0] got;
    got = dut_vec();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%03h expected=%03h", name, got, exp);
  endtask

  task automatic drive(logic rst, logic req, logic [2:0] pg);
    reset_reset      = rst;
    pwr_if.pwr_req_i = req;
    pwr_if.pg_1v2_i  = pg[0];
    pwr_if.pg_1v8_i  = pg[1];
    pwr_if.pg_3v3_i  = pg[2];
  endtask

  // One clock edge; every edge is also compared with the reference model.
  task automatic tick();
    model_step(reset_reset, pwr_if.pwr_req_i,
               {pwr_if.pg_3v3_i, pwr_if.pg_1v8_i, pwr_if.pg_1v2_i});
    @(posedge clk_clk);
    #1;
    check("model", model_vec());
  endtask

  task automatic run(string name, logic rst, logic req, logic [2:0] pg, int n, logic [11:0] exp);
    drive(rst, req, pg);
    repeat (n) tick();
    check(name, exp);
    $display("%s rst=%b req=%b pg=%b edges=%0d out=%03h", name, rst, req, pg, n, dut_vec());
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'b111);

    // Reset, full power-up, power-down with a re-request ignored until OFF.
    tbl.push_back(mk(1, 0, 7, 2,  12'h000));
    tbl.push_back(mk(0, 0, 7, 3,  12'h000));
    tbl.push_back(mk(0, 1, 7, 1,  12'h141));
    tbl.push_back(mk(0, 1, 7, 3,  12'h141));
    tbl.push_back(mk(0, 1, 7, 1,  12'h243));
    tbl.push_back(mk(0, 1, 7, 4,  12'h347));
    tbl.push_back(mk(0, 1, 7, 4,  12'h44F));
    tbl.push_back(mk(0, 1, 7, 2,  12'h44F));
    tbl.push_back(mk(0, 1, 7, 1,  12'h55F));
    tbl.push_back(mk(0, 1, 7, 4,  12'h55F));
    tbl.push_back(mk(0, 1, 7, 1,  12'h63F));
    tbl.push_back(mk(0, 1, 7, 3,  12'h63F));
    tbl.push_back(mk(0, 0, 7, 1,  12'h74F));
    tbl.push_back(mk(0, 1, 7, 1,  12'h74F));
    tbl.push_back(mk(0, 1, 7, 1,  12'h847));
    tbl.push_back(mk(0, 1, 7, 2,  12'h943));
    tbl.push_back(mk(0, 1, 7, 2,  12'hA41));
    tbl.push_back(mk(0, 1, 7, 2,  12'hB40));
    tbl.push_back(mk(0, 1, 7, 1,  12'hB40));
    tbl.push_back(mk(0, 1, 7, 1,  12'h000));
    // Re-request honoured from OFF, then abort during UP_1V8.
    tbl.push_back(mk(0, 1, 7, 1,  12'h141));
    tbl.push_back(mk(0, 1, 7, 3,  12'h141));
    tbl.push_back(mk(0, 1, 7, 1,  12'h243));
    tbl.push_back(mk(0, 0, 7, 3,  12'h243));
    tbl.push_back(mk(0, 0, 7, 1,  12'hA41));
    tbl.push_back(mk(0, 0, 7, 1,  12'hA41));
    tbl.push_back(mk(0, 0, 7, 1,  12'hB40));
    tbl.push_back(mk(0, 0, 7, 1,  12'hB40));
    tbl.push_back(mk(0, 0, 7, 1,  12'h000));
    // Abort during UP_1V2 and during UP_XCLR.
    tbl.push_back(mk(0, 1, 7, 1,  12'h141));
    tbl.push_back(mk(0, 0, 7, 3,  12'h141));
    tbl.push_back(mk(0, 0, 7, 1,  12'hB40));
    tbl.push_back(mk(0, 0, 7, 2,  12'h000));
    tbl.push_back(mk(0, 1, 7, 16, 12'h55F));
    tbl.push_back(mk(0, 0, 7, 4,  12'h55F));
    tbl.push_back(mk(0, 0, 7, 1,  12'h74F));
    tbl.push_back(mk(0, 0, 7, 10, 12'h000));
    // Reset while ON, then the full timing again.
    tbl.push_back(mk(0, 1, 7, 21, 12'h63F));
    tbl.push_back(mk(1, 1, 7, 1,  12'h000));
    tbl.push_back(mk(0, 1, 7, 20, 12'h55F));
    tbl.push_back(mk(0, 1, 7, 1,  12'h63F));
    tbl.push_back(mk(0, 0, 7, 11, 12'h000));

    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].pg, tbl[i].n, tbl[i].exp);
    end

`ifdef PG_CHECK_EN
    // 1V8 power-good never arrives: fault at the end of UP_1V8.
    run("pg1v8_up1v2",   0, 1, 3'b101, 1, 12'h141);
    run("pg1v8_in1v8",   0, 1, 3'b101, 7, 12'h243);
    run("pg1v8_fault",   0, 1, 3'b101, 1, 12'hF80);
    run("pg1v8_hold",    0, 1, 3'b101, 3, 12'hF80);
    run("pg1v8_clear",   0, 0, 3'b101, 1, 12'h000);
    // 3V3 glitch while ON, coinciding with a request drop.
    run("pg3v3_on",      0, 1, 3'b111, 21, 12'h63F);
    run("pg3v3_fault",   0, 0, 3'b011, 1, 12'hF80);
    run("pg3v3_clear",   0, 0, 3'b111, 1, 12'h000);
`else
    // Power-good is ignored in this build.
    run("pg_ign_on",     0, 1, 3'b111, 21, 12'h63F);
    run("pg_ign_low",    0, 1, 3'b000, 3, 12'h63F);
    run("pg_ign_down",   0, 0, 3'b000, 11, 12'h000);
`endif

    // Randomized run against the reference model.
    run("rand_reset", 1, 0, 3'b111, 2, 12'h000);
    begin
      logic       r_req;
      logic [2:0] r_pg;
      logic       r_rst;
      r_req = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 29) == 0) r_req = ~r_req;
        r_pg  = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(0, 6)) : 3'b111;
        r_rst = ($urandom_range(0, 399) == 0);
        drive(r_rst, r_req, r_pg);
        tick();
        if (c % 500 == 499)
          $display("rand cycle %0d req=%b out=%03h", c, r_req, dut_vec());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
